// File: rtl/ray_pkg.sv
// Shared types and helpers for ray_step_scaler: FSM states, default fraction
// width and a signed saturate-to-width helper.
package ray_pkg;

   localparam int FRAC_DEFAULT = 14;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_X = 2'd1,
      MUL_Y = 2'd2,
      MUL_Z = 2'd3
   } state_t;

   typedef struct packed {
      logic [63:0] value;
      logic        clip;
   } sat_t;

   // Clamp a 64-bit signed value into a w-bit signed range; clip flags a clamp.
   function automatic sat_t sat_to_width(input logic signed [63:0] a, input int unsigned w);
      sat_t              r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (a > hi) begin
         r.value = hi;
         r.clip  = 1'b1;
      end else if (a < lo) begin
         r.value = lo;
         r.clip  = 1'b1;
      end else begin
         r.value = a;
         r.clip  = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/lead_one_enc.sv
// Leading-one position encoder: k is the index of the highest set bit of m,
// zero is high when m has no set bit (k is then 0).
module lead_one_enc #(
   parameter int N  = 10,
   parameter int KW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  m,
   output logic [KW-1:0] k,
   output logic          zero
);

   // Scan upward so the highest set bit wins.
   always_comb begin
      k = {KW{1'b0}};
      for (int i = 0; i < N; i++) begin
         k = m[i] ? KW'(i) : k;
      end
   end

   // No bit set at all.
   always_comb begin
      zero = ~|m;
   end

endmodule

// File: rtl/ray_step_scaler.sv
// Scales a signed direction vector by a signed distance, either with a cheap
// leading-bit shift (1 cycle) or an exact shared-multiplier pass (3 cycles).
module ray_step_scaler
   import ray_pkg::*;
#(
   parameter int DW   = 11,
   parameter int VW   = 16,
   parameter int FRAC = FRAC_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_mode,
   input  logic [DW-1:0] in_d,
   input  logic [VW-1:0] in_x,
   input  logic [VW-1:0] in_y,
   input  logic [VW-1:0] in_z,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [VW-1:0] out_x,
   output logic [VW-1:0] out_y,
   output logic [VW-1:0] out_z,
   output logic          out_sat
);

   localparam int MW = DW - 1;
   localparam int KW = (MW > 1) ? $clog2(MW) : 1;
   localparam int PW = DW + VW;

   // The approximate shift FRAC-k must never go negative.
   if (DW < 3 || FRAC < DW - 2 || PW > 63) begin : g_param_check
      $error("ray_step_scaler: illegal DW/VW/FRAC combination");
   end

   state_t                state_r, next_s;
   logic                  accept_s;
   logic                  sign_s;
   logic [MW-1:0]         mag_s;
   logic [KW-1:0]         k_s;
   logic                  zero_s;
   logic [31:0]           sh_s;
   logic signed [VW-1:0]  ax_s, ay_s, az_s;
   logic signed [DW-1:0]  d_r;
   logic signed [VW-1:0]  x_r, y_r, z_r, axis_s, px_r, py_r;
   logic                  cx_r, cy_r;
   logic signed [PW-1:0]  prod_s, shr_s;
   sat_t                  sat_s;

   assign in_ready = (state_r == IDLE) && (!out_valid || out_ready);
   assign accept_s = in_valid && in_ready;

   // Approximate operand: fold negative distances to a ones-complement magnitude.
   always_comb begin
      sign_s = in_d[DW-1];
      mag_s  = sign_s ? ~in_d[DW-2:0] : in_d[DW-2:0];
      sh_s   = 32'(FRAC) - {{(32-KW){1'b0}}, k_s};
   end

   lead_one_enc #(.N(MW), .KW(KW)) u_lead (
      .m    (mag_s),
      .k    (k_s),
      .zero (zero_s)
   );

   // Approximate result: complement-then-arithmetic-shift per axis.
   always_comb begin
      if (zero_s) begin
         ax_s = {VW{1'b0}};
         ay_s = {VW{1'b0}};
         az_s = {VW{1'b0}};
      end else begin
         ax_s = $signed(sign_s ? ~in_x : in_x) >>> sh_s;
         ay_s = $signed(sign_s ? ~in_y : in_y) >>> sh_s;
         az_s = $signed(sign_s ? ~in_z : in_z) >>> sh_s;
      end
   end

   // Axis operand for the single multiplier, chosen by the current state.
   always_comb begin
      case (state_r)
         MUL_Y:   axis_s = y_r;
         MUL_Z:   axis_s = z_r;
         default: axis_s = x_r;
      endcase
   end

   // Low PW bits of the product are identical for signed or unsigned operands.
   always_comb begin
      prod_s = $signed({{VW{d_r[DW-1]}}, d_r}) * $signed({{DW{axis_s[VW-1]}}, axis_s});
      shr_s  = prod_s >>> FRAC;
      sat_s  = sat_to_width({{(64-PW){shr_s[PW-1]}}, shr_s}, VW);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // FSM next state: only exact-mode acceptances leave IDLE.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && in_mode) begin
               next_s = MUL_X;
            end else begin
               next_s = IDLE;
            end
         end
         MUL_X:   next_s = MUL_Y;
         MUL_Y:   next_s = MUL_Z;
         MUL_Z:   next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Operand capture on every acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_r <= {DW{1'b0}};
         x_r <= {VW{1'b0}};
         y_r <= {VW{1'b0}};
         z_r <= {VW{1'b0}};
      end else if (accept_s) begin
         d_r <= in_d;
         x_r <= in_x;
         y_r <= in_y;
         z_r <= in_z;
      end
   end

   // Partial exact results held until all three axes are done.
   always_ff @(posedge clk) begin
      if (reset) begin
         px_r <= {VW{1'b0}};
         py_r <= {VW{1'b0}};
         cx_r <= 1'b0;
         cy_r <= 1'b0;
      end else begin
         case (state_r)
            MUL_X: begin
               px_r <= sat_s.value[VW-1:0];
               cx_r <= sat_s.clip;
            end
            MUL_Y: begin
               py_r <= sat_s.value[VW-1:0];
               cy_r <= sat_s.clip;
            end
            default: begin
            end
         endcase
      end
   end

   // Output register: approximate load, exact load leaving MUL_Z, or drain.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_x     <= {VW{1'b0}};
         out_y     <= {VW{1'b0}};
         out_z     <= {VW{1'b0}};
         out_sat   <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept_s && !in_mode) begin
         out_x     <= ax_s;
         out_y     <= ay_s;
         out_z     <= az_s;
         out_sat   <= 1'b0;
         out_valid <= 1'b1;
      end else if (state_r == MUL_Z) begin
         out_x     <= px_r;
         out_y     <= py_r;
         out_z     <= sat_s.value[VW-1:0];
         out_sat   <= cx_r | cy_r | sat_s.clip;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ray_step_scaler.sv
// Randomized and directed bench for ray_step_scaler against a transaction-level
// arithmetic model (expected results queued with the cycle they must appear).
module tb_ray_step_scaler;

   localparam int DW = 11;
   localparam int VW = 16;

   logic          clk;
   logic          reset;
   logic          in_valid, in_valid2;
   logic          in_ready, in_ready2;
   logic          in_mode;
   logic [DW-1:0] in_d;
   logic [VW-1:0] in_x, in_y, in_z;
   logic          out_valid, out_valid2;
   logic          out_ready, out_ready2;
   logic [VW-1:0] out_x, out_y, out_z, o2_x, o2_y, o2_z;
   logic          out_sat, o2_sat;

   int checks = 0;
   int errors = 0;

   typedef struct {
      longint x, y, z;
      bit     sat;
      longint due;
   } item_t;

   item_t  q[$];
   longint now      = 0;
   longint busy_end = 0;

   ray_step_scaler #(.DW(DW), .VW(VW), .FRAC(14)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_d(in_d), .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_sat(out_sat)
   );

   // Smallest legal FRAC for DW=11, used to reach saturation.
   ray_step_scaler #(.DW(DW), .VW(VW), .FRAC(9)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_mode(in_mode), .in_d(in_d), .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .out_x(o2_x), .out_y(o2_y), .out_z(o2_z), .out_sat(o2_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic longint sx(input logic [VW-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint mdl_exact(input longint d, input longint v, input int frac, output bit clip);
      longint r;
      r = (d * v) >>> frac;
      clip = 1'b0;
      if (r > 32767) begin r = 32767; clip = 1'b1; end
      if (r < -32768) begin r = -32768; clip = 1'b1; end
      return r;
   endfunction

   function automatic longint mdl_approx(input longint d, input longint v, input int frac);
      longint m, vp;
      int k;
      m  = (d < 0) ? -d - 1 : d;
      vp = (d < 0) ? -v - 1 : v;
      if (m == 0) return 0;
      k = 0;
      while ((longint'(1) << (k + 1)) <= m) k++;
      return vp >>> (frac - k);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, now);
      end
   endtask

   task automatic cycle(input bit iv, input bit md, input longint d, input longint x,
                        input longint y, input longint z, input bit ordy);
      bit    ev, eir, c;
      item_t it;
      in_valid  = iv;
      in_mode   = md;
      in_d      = d[DW-1:0];
      in_x      = x[VW-1:0];
      in_y      = y[VW-1:0];
      in_z      = z[VW-1:0];
      out_ready = ordy;
      ev  = (q.size() > 0) && (q[0].due <= now);
      eir = (now >= busy_end) && (!ev || ordy);
      #1;
      chk("in_ready", in_ready, eir);
      if (ev && ordy) it = q.pop_front();
      if (iv && eir) begin
         if (md) begin
            it.x   = mdl_exact(d, x, 14, c); it.sat = c;
            it.y   = mdl_exact(d, y, 14, c); it.sat = it.sat | c;
            it.z   = mdl_exact(d, z, 14, c); it.sat = it.sat | c;
            it.due = now + 4;
            busy_end = now + 4;
         end else begin
            it.x   = mdl_approx(d, x, 14);
            it.y   = mdl_approx(d, y, 14);
            it.z   = mdl_approx(d, z, 14);
            it.sat = 1'b0;
            it.due = now + 1;
         end
         q.push_back(it);
      end
      @(posedge clk);
      now++;
      #1;
      ev = (q.size() > 0) && (q[0].due <= now);
      chk("out_valid", out_valid, ev);
      if (ev) begin
         chk("out_x", sx(out_x), q[0].x);
         chk("out_y", sx(out_y), q[0].y);
         chk("out_z", sx(out_z), q[0].z);
         chk("out_sat", out_sat, q[0].sat);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      in_valid2 = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      now += 2;
      #1;
      reset = 1'b0;
      q.delete();
      busy_end = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_x", sx(out_x), 0);
      chk("rst_out_y", sx(out_y), 0);
      chk("rst_out_z", sx(out_z), 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_in_ready", in_ready, 1);
   endtask

   function automatic longint rnd_s(input int w);
      longint u;
      u = longint'($urandom_range(0, (1 << w) - 1));
      return (u >= (longint'(1) << (w - 1))) ? u - (longint'(1) << w) : u;
   endfunction

   initial begin
      bit c;
      in_valid = 1'b0; in_valid2 = 1'b0; in_mode = 1'b0;
      in_d = '0; in_x = '0; in_y = '0; in_z = '0;
      out_ready = 1'b0; out_ready2 = 1'b1;
      reset = 1'b1;

      chk("pin_approx_pos", mdl_approx(300, 16384, 14), 256);
      chk("pin_approx_neg", mdl_approx(-300, 16384, 14), -257);
      chk("pin_exact_z", mdl_exact(300, 100, 14, c), 1);
      chk("pin_exact_sat", mdl_exact(1023, -32768, 9, c), -32768);

      do_reset();

      // approximate, positive then negative distance (drain + accept)
      cycle(1, 0, 300, 16384, -16384, 100, 1);
      chk("a_x", sx(out_x), 256);
      chk("a_y", sx(out_y), -256);
      chk("a_z", sx(out_z), 1);
      cycle(1, 0, -300, 16384, 0, 0, 1);
      chk("an_x", sx(out_x), -257);

      // exact, with in_valid held high while busy
      cycle(1, 1, 300, 16384, -16384, 100, 1);
      cycle(1, 0, 5, 5, 5, 5, 1);
      cycle(1, 0, 5, 5, 5, 5, 1);
      chk("e_not_yet", out_valid, 0);
      cycle(1, 0, 5, 5, 5, 5, 0);
      chk("e_valid", out_valid, 1);
      chk("e_x", sx(out_x), 300);
      chk("e_y", sx(out_y), -300);
      chk("e_z", sx(out_z), 1);
      chk("e_sat", out_sat, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);

      // backpressure then drain + accept on the same edge
      cycle(1, 0, 1000, 12345, -777, 32767, 1);
      repeat (5) cycle(1, 1, rnd_s(DW), rnd_s(VW), rnd_s(VW), rnd_s(VW), 0);
      cycle(1, 1, 300, 16384, -16384, 100, 1);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 1);
      chk("bp_exact_x", sx(out_x), 300);

      // saturation on the FRAC=9 instance
      chk("s_in_ready", in_ready2, 1);
      in_valid2 = 1'b1;
      cycle(0, 1, 1023, 32767, -32768, 0, 1);
      in_valid2 = 1'b0;
      cycle(0, 1, 1023, 32767, -32768, 0, 1);
      cycle(0, 1, 1023, 32767, -32768, 0, 1);
      chk("s_not_yet", out_valid2, 0);
      cycle(0, 1, 1023, 32767, -32768, 0, 1);
      chk("s_valid", out_valid2, 1);
      chk("s_x", sx(o2_x), 32767);
      chk("s_y", sx(o2_y), -32768);
      chk("s_z", sx(o2_z), 0);
      chk("s_sat", o2_sat, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);

      // reset while in MUL_Y discards the transaction
      cycle(1, 1, 300, 1, 2, 3, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      do_reset();
      repeat (4) cycle(0, 0, 0, 0, 0, 0, 1);

      // zero distance in both modes
      cycle(1, 0, 0, 1234, -5, 32767, 1);
      chk("z_a_x", sx(out_x), 0);
      chk("z_a_y", sx(out_y), 0);
      chk("z_a_z", sx(out_z), 0);
      cycle(1, 1, 0, -32768, 77, 1, 1);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 1);
      chk("z_e_x", sx(out_x), 0);
      chk("z_e_y", sx(out_y), 0);
      chk("z_e_z", sx(out_z), 0);

      // randomized traffic with random backpressure
      for (int i = 0; i < 600; i++) begin
         longint x;
         x = ($urandom_range(0, 7) == 0) ? -32768 : rnd_s(VW);
         cycle($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, rnd_s(DW),
               x, rnd_s(VW), rnd_s(VW), $urandom_range(0, 9) < 7);
      end
      repeat (5) cycle(0, 0, 0, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
